// File: rtl/re_mapper_slot.sv
// Uplink slot RE mapper: walks Sym_Start..Sym_End, writing DMRS comb pilots/zeros
// or FFT data for every allocated subcarrier into the RE grid through a registered write port.
module re_mapper_slot #(
    parameter int DATA_W     = 18,
    parameter int DMRS_W     = 9,
    parameter int N_SC_TOTAL = 1200,
    parameter int N_SYM      = 14,
    parameter int ADDR_W     = 11
) (
    input  logic                     CLK_RE,
    input  logic                     RST_RE,
    input  logic                     Start,
    input  logic                     Abort,
    input  logic [ADDR_W-1:0]        N_sc,
    input  logic [6:0]               N_rb,
    input  logic [3:0]               Sym_Start,
    input  logic [3:0]               Sym_End,
    input  logic [N_SYM-1:0]         Dmrs_Map,
    input  logic                     Comb,
    input  logic signed [DMRS_W-1:0] Dmrs_I,
    input  logic signed [DMRS_W-1:0] Dmrs_Q,
    input  logic                     Dmrs_Valid,
    output logic                     Dmrs_Ready,
    input  logic signed [DATA_W-1:0] FFT_I,
    input  logic signed [DATA_W-1:0] FFT_Q,
    input  logic                     FFT_Valid,
    output logic                     FFT_Ready,
    output logic                     Wr_en,
    output logic [3:0]               Wr_sym,
    output logic [ADDR_W-1:0]        Wr_addr,
    output logic signed [DATA_W-1:0] Wr_I,
    output logic signed [DATA_W-1:0] Wr_Q,
    output logic                     Sym_Done,
    output logic                     RE_Done,
    output logic                     Cfg_Err,
    output logic                     Busy
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SETUP    = 3'd1;
    localparam logic [2:0] MAP_DMRS = 3'd2;
    localparam logic [2:0] MAP_DATA = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] k, n_sc_q, n_re_q;
    logic [3:0]        sym, sym_end_q;
    logic [N_SYM-1:0]  dmrs_map_q;
    logic              comb_q;

    // One extra bit so an allocation running past the grid edge cannot wrap.
    logic [ADDR_W:0] n_re_in, alloc_end;
    logic            cfg_bad;
    assign n_re_in   = (ADDR_W+1)'({N_rb, 3'b000}) + (ADDR_W+1)'({N_rb, 2'b00});
    assign alloc_end = {1'b0, N_sc} + n_re_in;
    assign cfg_bad   = (N_rb == 7'd0) || (alloc_end > (ADDR_W+1)'(N_SC_TOTAL)) ||
                       (Sym_End < Sym_Start) || (int'(Sym_End) >= N_SYM);

    logic pilot, last_k, accept;
    logic signed [DATA_W-1:0] dmrs_i_ext, dmrs_q_ext;
    assign pilot      = (k[0] == comb_q);
    assign last_k     = (k == n_re_q - ADDR_W'(1));
    assign dmrs_i_ext = DATA_W'(Dmrs_I);
    assign dmrs_q_ext = DATA_W'(Dmrs_Q);

    assign Dmrs_Ready = (state == MAP_DMRS) && pilot && !Abort;
    assign FFT_Ready  = (state == MAP_DATA) && !Abort;
    // Non-pilot DMRS positions advance without consuming any input.
    assign accept     = !Abort && (((state == MAP_DMRS) && (!pilot || Dmrs_Valid)) ||
                                   ((state == MAP_DATA) && FFT_Valid));
    assign Busy       = (state != IDLE);

    always_ff @(posedge CLK_RE or negedge RST_RE) begin
        if (!RST_RE) begin
            state      <= IDLE;
            k          <= '0;
            sym        <= '0;
            n_sc_q     <= '0;
            n_re_q     <= '0;
            sym_end_q  <= '0;
            dmrs_map_q <= '0;
            comb_q     <= 1'b0;
            Wr_en      <= 1'b0;
            Wr_sym     <= '0;
            Wr_addr    <= '0;
            Wr_I       <= '0;
            Wr_Q       <= '0;
            Sym_Done   <= 1'b0;
            RE_Done    <= 1'b0;
            Cfg_Err    <= 1'b0;
        end else begin
            Wr_en    <= accept;
            Sym_Done <= accept && last_k;
            RE_Done  <= 1'b0;
            Cfg_Err  <= 1'b0;
            if (accept) begin
                Wr_sym  <= sym;
                Wr_addr <= n_sc_q + k;
                Wr_I    <= (state == MAP_DATA) ? FFT_I : (pilot ? dmrs_i_ext : '0);
                Wr_Q    <= (state == MAP_DATA) ? FFT_Q : (pilot ? dmrs_q_ext : '0);
            end
            if (Abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (Start) begin
                        if (cfg_bad) begin
                            Cfg_Err <= 1'b1;
                        end else begin
                            n_sc_q     <= N_sc;
                            n_re_q     <= n_re_in[ADDR_W-1:0];
                            sym        <= Sym_Start;
                            sym_end_q  <= Sym_End;
                            dmrs_map_q <= Dmrs_Map;
                            comb_q     <= Comb;
                            state      <= SETUP;
                        end
                    end
                    SETUP: begin
                        k     <= '0;
                        state <= dmrs_map_q[sym] ? MAP_DMRS : MAP_DATA;
                    end
                    MAP_DMRS, MAP_DATA: if (accept) begin
                        if (last_k) begin
                            if (sym == sym_end_q) begin
                                state <= DONE;
                            end else begin
                                sym   <= sym + 4'd1;
                                state <= SETUP;
                            end
                        end else begin
                            k <= k + ADDR_W'(1);
                        end
                    end
                    DONE: begin
                        RE_Done <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_re_mapper_slot.sv
// Randomised bench for re_mapper_slot: a slot-level model lists every expected grid
// write in order, and the observed write stream is compared against it.
module tb_re_mapper_slot;
    localparam int DATA_W = 18;
    localparam int DMRS_W = 9;
    localparam int ADDR_W = 11;
    localparam int NSAMP  = 16800;

    logic CLK_RE = 1'b0;
    logic RST_RE = 1'b0;
    always #5 CLK_RE = ~CLK_RE;

    logic Start = 0, Abort = 0, Comb = 0, Dmrs_Valid = 0, FFT_Valid = 0;
    logic [ADDR_W-1:0] N_sc = '0;
    logic [6:0] N_rb = '0;
    logic [3:0] Sym_Start = '0, Sym_End = '0;
    logic [13:0] Dmrs_Map = '0;
    logic signed [DMRS_W-1:0] Dmrs_I = '0, Dmrs_Q = '0;
    logic signed [DATA_W-1:0] FFT_I = '0, FFT_Q = '0;
    logic Dmrs_Ready, FFT_Ready, Wr_en, Sym_Done, RE_Done, Cfg_Err, Busy;
    logic [3:0] Wr_sym;
    logic [ADDR_W-1:0] Wr_addr;
    logic signed [DATA_W-1:0] Wr_I, Wr_Q;

    re_mapper_slot dut (
        .CLK_RE(CLK_RE), .RST_RE(RST_RE), .Start(Start), .Abort(Abort), .N_sc(N_sc), .N_rb(N_rb),
        .Sym_Start(Sym_Start), .Sym_End(Sym_End), .Dmrs_Map(Dmrs_Map), .Comb(Comb),
        .Dmrs_I(Dmrs_I), .Dmrs_Q(Dmrs_Q), .Dmrs_Valid(Dmrs_Valid), .Dmrs_Ready(Dmrs_Ready),
        .FFT_I(FFT_I), .FFT_Q(FFT_Q), .FFT_Valid(FFT_Valid), .FFT_Ready(FFT_Ready),
        .Wr_en(Wr_en), .Wr_sym(Wr_sym), .Wr_addr(Wr_addr), .Wr_I(Wr_I), .Wr_Q(Wr_Q),
        .Sym_Done(Sym_Done), .RE_Done(RE_Done), .Cfg_Err(Cfg_Err), .Busy(Busy)
    );

    typedef struct {
        logic [3:0]               sym;
        logic [ADDR_W-1:0]        addr;
        logic signed [DATA_W-1:0] i, q;
        logic                     last;
    } exp_t;

    int vectors = 0, miscompares = 0;
    int dmrs_i[NSAMP], dmrs_q[NSAMP], fft_i[NSAMP], fft_q[NSAMP];

    // mode 0: streams always valid; 1: random valids plus stray Start pulses;
    // 2: FFT_Valid alternates and Dmrs_Valid drops for 3 ready cycles at the third pilot.
    task automatic run_slot(input string name, input int nsc, input int nrb, input int ss, input int se,
                            input logic [13:0] map, input logic cmb, input int mode,
                            input int abort_after, input int reset_after);
        exp_t exp_q[$];
        exp_t e;
        int d, f, di, fi, wr_cnt, sd_cnt, rd_cnt, cyc, last_wr, gap, max_addr, budget;
        bit stall_prev, done, bad;
        d = 0; f = 0;
        for (int s = ss; s <= se; s++)
            for (int k = 0; k < 12*nrb; k++) begin
                e.sym = 4'(s); e.addr = ADDR_W'(nsc + k); e.last = (k == 12*nrb - 1);
                if (map[s]) begin
                    if (k % 2 == int'(cmb)) begin
                        e.i = DATA_W'(dmrs_i[d]); e.q = DATA_W'(dmrs_q[d]); d++;
                    end else begin
                        e.i = '0; e.q = '0;
                    end
                end else begin
                    e.i = DATA_W'(fft_i[f]); e.q = DATA_W'(fft_q[f]); f++;
                end
                exp_q.push_back(e);
            end
        @(negedge CLK_RE);
        N_sc = ADDR_W'(nsc); N_rb = 7'(nrb); Sym_Start = 4'(ss); Sym_End = 4'(se);
        Dmrs_Map = map; Comb = cmb; Start = 1;
        di = 0; fi = 0; wr_cnt = 0; sd_cnt = 0; rd_cnt = 0; cyc = 0; last_wr = -10; gap = 0; max_addr = -1;
        stall_prev = 0; done = 0;
        budget = 12*nrb*(se - ss + 1)*6 + 60;
        while (!done) begin
            @(negedge CLK_RE);
            cyc++; Start = 0;
            if (Wr_en) begin
                wr_cnt++; vectors++;
                if (int'(Wr_addr) > max_addr) max_addr = int'(Wr_addr);
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra write: got sym=%0d addr=%0d, want no write", name, Wr_sym, Wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    last_wr = cyc;
                    if ({Wr_sym, Wr_addr, Wr_I, Wr_Q, Sym_Done} !== {e.sym, e.addr, e.i, e.q, e.last}) begin
                        miscompares++;
                        $display("FAIL %s write%0d: got sym=%0d addr=%0d i=%0d q=%0d sd=%0b want sym=%0d addr=%0d i=%0d q=%0d sd=%0b",
                                 name, wr_cnt, Wr_sym, Wr_addr, Wr_I, Wr_Q, Sym_Done, e.sym, e.addr, e.i, e.q, e.last);
                    end
                end
                if (Sym_Done) sd_cnt++;
            end else begin
                vectors++;
                if (Sym_Done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s sym_done_no_write: got Sym_Done=%b want 0", name, Sym_Done);
                end
            end
            if (stall_prev) begin
                vectors++;
                if (Wr_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s stall_write: got Wr_en=%b after stalled cycle want 0", name, Wr_en);
                end
            end
            if (RE_Done) begin
                rd_cnt++; vectors++; done = 1;
                if (cyc != last_wr + 1 || Busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s re_done_timing: got delay=%0d Busy=%b want delay=1 Busy=0", name, cyc - last_wr, Busy);
                end
            end
            if (!done && cyc > budget) begin
                miscompares++; done = 1;
                $display("FAIL %s timeout: got no RE_Done within %0d cycles want RE_Done", name, budget);
            end
            if (done) break;
            if (abort_after >= 0 && wr_cnt == abort_after) begin
                Abort = 1; Dmrs_Valid = 1; FFT_Valid = 1;
                #1;
                vectors++;
                if (Dmrs_Ready !== 1'b0 || FFT_Ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s abort_ready: got Dmrs_Ready=%b FFT_Ready=%b want 0 0", name, Dmrs_Ready, FFT_Ready);
                end
                @(negedge CLK_RE);
                Abort = 0;
                vectors++;
                if (Busy !== 1'b0 || Wr_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s abort_idle: got Busy=%b Wr_en=%b want 0 0", name, Busy, Wr_en);
                end
                bad = 0;
                repeat (20) begin
                    @(negedge CLK_RE);
                    if (Wr_en || Sym_Done || RE_Done || Busy || Dmrs_Ready || FFT_Ready) bad = 1;
                end
                vectors++;
                if (bad) begin
                    miscompares++;
                    $display("FAIL %s abort_quiet: got activity after abort want none", name);
                end
                Dmrs_Valid = 0; FFT_Valid = 0;
                return;
            end
            if (reset_after >= 0 && wr_cnt == reset_after) begin
                #2 RST_RE = 0;
                #1;
                vectors++;
                if ({Wr_en, Wr_sym, Wr_addr, Wr_I, Wr_Q, Sym_Done, RE_Done, Cfg_Err, Busy, Dmrs_Ready, FFT_Ready} !== '0) begin
                    miscompares++;
                    $display("FAIL %s reset_mid: got Wr_en=%b addr=%0d sym=%0d Busy=%b ready=%b%b want all 0",
                             name, Wr_en, Wr_addr, Wr_sym, Busy, Dmrs_Ready, FFT_Ready);
                end
                @(negedge CLK_RE);
                RST_RE = 1; Dmrs_Valid = 0; FFT_Valid = 0;
                return;
            end
            case (mode)
                1: begin
                    Dmrs_Valid = ($urandom_range(0, 3) != 0);
                    FFT_Valid  = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 40) == 0) begin
                        Start = 1; N_sc = ADDR_W'($urandom_range(0, 2047)); N_rb = 7'($urandom);
                        Dmrs_Map = 14'($urandom); Comb = 1'($urandom); Sym_End = 4'($urandom);
                    end
                end
                2: begin Dmrs_Valid = 1; FFT_Valid = cyc[0]; end
                default: begin Dmrs_Valid = 1; FFT_Valid = 1; end
            endcase
            Dmrs_I = DMRS_W'(dmrs_i[di % NSAMP]); Dmrs_Q = DMRS_W'(dmrs_q[di % NSAMP]);
            FFT_I  = DATA_W'(fft_i[fi % NSAMP]);  FFT_Q  = DATA_W'(fft_q[fi % NSAMP]);
            #1;
            if (mode == 2 && di == 2 && gap < 3 && Dmrs_Ready) begin
                Dmrs_Valid = 0; gap++;
            end
            vectors++;
            if (Dmrs_Ready && FFT_Ready) begin
                miscompares++;
                $display("FAIL %s ready_excl: got Dmrs_Ready=1 FFT_Ready=1 want at most one", name);
            end
            stall_prev = (Dmrs_Ready && !Dmrs_Valid) || (FFT_Ready && !FFT_Valid);
            if (Dmrs_Ready && Dmrs_Valid) di++;
            if (FFT_Ready && FFT_Valid) fi++;
        end
        Dmrs_Valid = 0; FFT_Valid = 0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s missing_writes: got %0d writes, %0d still expected want 0", name, wr_cnt, exp_q.size());
        end
        vectors++;
        if (sd_cnt != se - ss + 1 || rd_cnt != 1) begin
            miscompares++;
            $display("FAIL %s done_counts: got sym_done=%0d re_done=%0d want %0d 1", name, sd_cnt, rd_cnt, se - ss + 1);
        end
        vectors++;
        if (di != d || fi != f) begin
            miscompares++;
            $display("FAIL %s consumed: got dmrs=%0d fft=%0d want dmrs=%0d fft=%0d", name, di, fi, d, f);
        end
        vectors++;
        if (max_addr != nsc + 12*nrb - 1) begin
            miscompares++;
            $display("FAIL %s max_addr: got %0d want %0d", name, max_addr, nsc + 12*nrb - 1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK_RE);
        vectors++;
        if ({Wr_en, Wr_sym, Wr_addr, Wr_I, Wr_Q, Sym_Done, RE_Done, Cfg_Err, Busy, Dmrs_Ready, FFT_Ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got Wr_en=%b Busy=%b Cfg_Err=%b addr=%0d want all 0", Wr_en, Busy, Cfg_Err, Wr_addr);
        end
        RST_RE = 1;
    endtask

    task automatic test_basic();
        run_slot("basic", 24, 1, 0, 3, 14'h0004, 1'b0, 0, -1, -1);
        run_slot("comb1", 24, 1, 0, 3, 14'h0004, 1'b1, 0, -1, -1);
        run_slot("edge_single_sym", 1188, 1, 13, 13, 14'h2000, 1'b1, 0, -1, -1);
    endtask

    task automatic test_stall();
        run_slot("stall", 24, 1, 0, 3, 14'h0004, 1'b0, 2, -1, -1);
        for (int t = 0; t < 5; t++) begin
            int nrb, nsc, ss, se;
            nrb = $urandom_range(1, 4);
            nsc = $urandom_range(0, 1200 - 12*nrb);
            ss  = $urandom_range(0, 13);
            se  = $urandom_range(ss, (ss + 2 > 13) ? 13 : ss + 2);
            run_slot("random", nsc, nrb, ss, se, 14'($urandom), 1'($urandom), 1, -1, -1);
        end
    endtask

    task automatic test_cfg_err();
        int tbl[5][4] = '{'{1190, 1, 0, 3}, '{24, 1, 5, 4}, '{24, 0, 0, 3}, '{24, 1, 0, 14}, '{2000, 100, 0, 0}};
        bit bad;
        for (int t = 0; t < 5; t++) begin
            @(negedge CLK_RE);
            N_sc = ADDR_W'(tbl[t][0]); N_rb = 7'(tbl[t][1]); Sym_Start = 4'(tbl[t][2]); Sym_End = 4'(tbl[t][3]);
            Start = 1; Dmrs_Valid = 1; FFT_Valid = 1;
            @(negedge CLK_RE);
            Start = 0;
            vectors++;
            if (Cfg_Err !== 1'b1 || Busy !== 1'b0) begin
                miscompares++;
                $display("FAIL cfg_err%0d: got Cfg_Err=%b Busy=%b want 1 0", t, Cfg_Err, Busy);
            end
            bad = 0;
            repeat (4) begin
                @(negedge CLK_RE);
                if (Cfg_Err || Busy || Wr_en) bad = 1;
            end
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL cfg_err%0d_after: got activity after error pulse want none", t);
            end
        end
        Dmrs_Valid = 0; FFT_Valid = 0;
    endtask

    task automatic test_abort();
        run_slot("abort", 24, 1, 0, 3, 14'h0004, 1'b0, 0, 19, -1);
        @(negedge CLK_RE);
        N_sc = 24; N_rb = 1; Sym_Start = 0; Sym_End = 3; Start = 1; Abort = 1;
        @(negedge CLK_RE);
        Start = 0; Abort = 0;
        vectors++;
        if (Busy !== 1'b0 || Cfg_Err !== 1'b0) begin
            miscompares++;
            $display("FAIL start_abort: got Busy=%b Cfg_Err=%b want 0 0", Busy, Cfg_Err);
        end
        run_slot("after_abort", 24, 1, 0, 3, 14'h0004, 1'b0, 0, -1, -1);
    endtask

    task automatic test_big();
        run_slot("full_grid", 0, 100, 0, 13, 14'h0804, 1'b0, 0, -1, -1);
    endtask

    task automatic test_reset_mid();
        run_slot("reset_mid", 0, 100, 0, 13, 14'h0804, 1'b1, 0, -1, 5*1200 + 600);
        run_slot("after_reset", 24, 1, 0, 3, 14'h0004, 1'b1, 0, -1, -1);
    endtask

    initial begin
        for (int n = 0; n < NSAMP; n++) begin
            dmrs_i[n] = $urandom_range(0, 511) - 256;
            dmrs_q[n] = $urandom_range(0, 511) - 256;
            fft_i[n]  = $urandom_range(0, 262143) - 131072;
            fft_q[n]  = $urandom_range(0, 262143) - 131072;
        end
        test_reset();
        test_basic();
        test_stall();
        test_cfg_err();
        test_abort();
        test_big();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/re_mapper_slot.md
Name: re_mapper_slot

Overview:
- Parametrised successor of the single-DMRS PUSCH resource-element mapper. Maps one full uplink slot into the RE grid memory.
- Each allocated OFDM symbol is either a DMRS symbol or a data symbol, chosen by a per-symbol bitmap. DMRS symbols carry comb-interleaved pilots and zeros; data symbols carry FFT/transform-precoder output.
- Sits between the DMRS generator / FFT stages and the RE grid RAM. Both inputs use valid/ready streams; the output is a registered write port.

Parameters:
- DATA_W, 18, width of I/Q data and output samples.
- DMRS_W, 9, width of DMRS I/Q samples (must be <= DATA_W).
- N_SC_TOTAL, 1200, subcarriers per symbol in the grid.
- N_SYM, 14, OFDM symbols per slot.
- ADDR_W, 11, subcarrier address width.

Ports:
- CLK_RE  in  1  clock.
- RST_RE  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse; latches the configuration.
- Abort  in  1  synchronous abort.
- N_sc  in  ADDR_W  first subcarrier of the allocation.
- N_rb  in  7  allocated RBs.
- Sym_Start, Sym_End  in  4 each  first and last allocated symbol (inclusive).
- Dmrs_Map  in  N_SYM  bit l=1 means symbol l is a DMRS symbol.
- Comb  in  1  DMRS comb offset (0 = even k, 1 = odd k).
- Dmrs_I, Dmrs_Q  in  DMRS_W signed each  DMRS sample.
- Dmrs_Valid  in  1.
- Dmrs_Ready  out  1.
- FFT_I, FFT_Q  in  DATA_W signed each  data sample.
- FFT_Valid  in  1.
- FFT_Ready  out  1.
- Wr_en  out  1  grid write strobe.
- Wr_sym  out  4  symbol index of the write.
- Wr_addr  out  ADDR_W  subcarrier address of the write.
- Wr_I, Wr_Q  out  DATA_W signed each  write data.
- Sym_Done  out  1  pulse with the last write of each symbol.
- RE_Done  out  1  slot-complete pulse.
- Cfg_Err  out  1  invalid-configuration pulse.
- Busy  out  1  high while not IDLE.

Behaviour:
- Reset values: state=IDLE; all outputs and counters 0.
- Configuration is latched on Start in IDLE. Start is ignored when not IDLE.
- Configuration check, registered; the result is visible the cycle after Start. The configuration is invalid if any of these hold:
  - N_rb == 0
  - N_sc + 12*N_rb > N_SC_TOTAL (evaluated at ADDR_W+1 bits, no wrap)
  - Sym_End < Sym_Start
  - Sym_End >= N_SYM
- Invalid configuration: Cfg_Err pulses for 1 cycle and the block stays IDLE. No writes occur.
- States:
  - IDLE: valid Start -> SETUP.
  - SETUP: 1 bubble cycle. k=0. If Dmrs_Map[sym]=1 -> MAP_DMRS, else -> MAP_DATA.
  - MAP_DMRS: runs k = 0..12*N_rb-1.
    - Pilot position (k[0]==Comb): Dmrs_Ready=1. A write occurs only on Dmrs_Valid, using the sign-extended Dmrs_I/Q. If Dmrs_Valid=0, k holds and Wr_en=0.
    - Non-pilot position: writes 0+j0 without consuming input; Dmrs_Ready=0.
  - MAP_DATA: FFT_Ready=1. Each FFT_Valid cycle writes FFT_I/Q and increments k. Gaps in FFT_Valid stall k.
  - End of symbol: after the write at k = 12*N_rb-1, Sym_Done pulses in the same cycle as that write. Then sym==Sym_End -> DONE, else sym++ -> SETUP.
  - DONE: RE_Done=1 for 1 cycle, then -> IDLE.
- Write port:
  - Wr_addr = N_sc + k; Wr_sym = current symbol.
  - Registered: Wr_* appear 1 cycle after the accepting cycle.
  - Exactly one write per k, in ascending address order.
- Ready signals: Dmrs_Ready and FFT_Ready are never both high. Both are 0 in IDLE, SETUP and DONE.
- Abort, any state: next cycle -> IDLE. Ready signals drop immediately (combinational). Wr_en=0 from the next cycle. No Sym_Done or RE_Done. Partial symbols are not completed.
- Start and Abort in the same cycle: Abort wins.
- Reset mid-slot: immediate return to IDLE with all outputs 0. The latched configuration is discarded.
- k width: 11 bits. Max 12*100=1200 REs per symbol.
- Single-symbol slot (Sym_Start == Sym_End) is legal.

Test Plan:
- Basic slot: N_sc=24, N_rb=1, Sym 0..3, Dmrs_Map=0x0004, Comb=0, streams always valid.
  - Symbols 0, 1, 3: 12 data writes each at addr 24..35.
  - Symbol 2: DMRS at addr 24,26,...,34; zeros at 25,...,35; exactly 6 DMRS samples consumed.
  - 48 writes total; 4 Sym_Done pulses; RE_Done 1 cycle after the final write.
- Comb=1, same configuration: DMRS written at addr 25,27,...,35; zeros at 24,...,34.
- Stall: FFT_Valid toggles 1,0,1,0 during a data symbol.
  - Writes only follow valid cycles; addresses stay contiguous with no duplicates.
  - Dmrs_Valid=0 for 3 cycles at k=4: the zero at k=3 is written, then the block holds at k=4 with Wr_en=0.
- Config errors:
  - N_sc=1190, N_rb=1 -> Cfg_Err pulse, Busy stays 0, no writes.
  - Sym_Start=5, Sym_End=4 -> Cfg_Err.
- Abort at k=7 of symbol 1 -> IDLE the next cycle, Ready signals low, no RE_Done. A new Start then runs a full slot correctly.
- Two DMRS symbols (Dmrs_Map=0x0804, Sym 0..13, N_rb=100, N_sc=0):
  - 16800 writes total; 1200 DMRS samples consumed; max Wr_addr = 1199.
  - Reset asserted mid-symbol 5 -> all outputs 0 immediately.
